// File: rtl/ccp_fill_pkg.sv
// Shared types and geometry for the CCP fill transmitter.
package ccp_fill_pkg;

  localparam int unsigned N_WAYS          = 2;
  localparam int unsigned WAY_POINTER_W   = $clog2(N_WAYS);
  localparam int unsigned CACHE_STATE_W   = 2;
  localparam int unsigned DATA_W          = 129;
  localparam int unsigned ADDRESS_W       = 32;
  localparam int unsigned BURST_LEN_W     = 2;
  localparam int unsigned MAX_BEAT        = 1 << BURST_LEN_W;
  localparam int unsigned TABLE_ENTRIES   = 64;
  localparam int unsigned TABLE_ENTRIES_W = $clog2(TABLE_ENTRIES);
  localparam int unsigned QUEUE_DEPTH     = 4;

  typedef struct packed {
    logic [TABLE_ENTRIES_W-1:0] id;
    logic [ADDRESS_W-1:0]       address;
    logic [WAY_POINTER_W-1:0]   way;
    logic [CACHE_STATE_W-1:0]   state;
    logic                       security;
    logic [BURST_LEN_W-1:0]     beat;
  } fill_req_t;

  typedef struct packed {
    logic [DATA_W-1:0]          data;
    logic [TABLE_ENTRIES_W-1:0] id;
    logic [ADDRESS_W-1:0]       address;
    logic [WAY_POINTER_W-1:0]   way;
    logic [BURST_LEN_W-1:0]     beat;
  } fill_beat_t;

  // Beat number wraps modulo MAX_BEAT through the natural width truncation.
  function automatic logic [BURST_LEN_W-1:0] beat_at(input logic [BURST_LEN_W-1:0] start,
                                                     input logic [BURST_LEN_W-1:0] cnt);
    return start + cnt;
  endfunction

endpackage

// File: rtl/ccp_fill_req_fifo.sv
// Queue of accepted fill requests waiting for their data beats.
module ccp_fill_req_fifo
  import ccp_fill_pkg::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  fill_req_t push_data,
  input  logic      pop,
  output fill_req_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fill_req_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/ccp_fill_ctrl_tx.sv
// CCP fill-interface transmitter: fill-state channel, fill-data channel, busy-id tracking.
// Optional sticky protocol checker built only when CCP_FILL_TX_ERR_CHK_EN is defined.
module ccp_fill_ctrl_tx
  import ccp_fill_pkg::*;
#(
  parameter int unsigned N_WAYS          = ccp_fill_pkg::N_WAYS,
  parameter int unsigned WAY_POINTER_W   = $clog2(N_WAYS),
  parameter int unsigned CACHE_STATE_W   = ccp_fill_pkg::CACHE_STATE_W,
  parameter int unsigned DATA_W          = ccp_fill_pkg::DATA_W,
  parameter int unsigned ADDRESS_W       = ccp_fill_pkg::ADDRESS_W,
  parameter int unsigned BURST_LEN_W     = ccp_fill_pkg::BURST_LEN_W,
  parameter int unsigned TABLE_ENTRIES   = ccp_fill_pkg::TABLE_ENTRIES,
  parameter int unsigned TABLE_ENTRIES_W = $clog2(TABLE_ENTRIES),
  parameter int unsigned QUEUE_DEPTH     = ccp_fill_pkg::QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fill_req_valid,
  output logic                       fill_req_ready,
  input  logic [TABLE_ENTRIES_W-1:0] fill_req_id,
  input  logic [ADDRESS_W-1:0]       fill_req_address,
  input  logic [WAY_POINTER_W-1:0]   fill_req_way_num,
  input  logic [CACHE_STATE_W-1:0]   fill_req_state,
  input  logic                       fill_req_security,
  input  logic [BURST_LEN_W-1:0]     fill_req_beat_num,
  input  logic                       beat_in_valid,
  output logic                       beat_in_ready,
  input  logic [DATA_W-1:0]          beat_in_data,
  output logic                       ctrl_fill_valid,
  output logic [ADDRESS_W-1:0]       ctrl_fill_address,
  output logic [WAY_POINTER_W-1:0]   ctrl_fill_way_num,
  output logic [CACHE_STATE_W-1:0]   ctrl_fill_state,
  output logic                       ctrl_fill_security,
  input  logic                       cache_fill_ready,
  output logic                       ctrl_fill_data_valid,
  output logic [DATA_W-1:0]          ctrl_fill_data,
  output logic [TABLE_ENTRIES_W-1:0] ctrl_fill_data_id,
  output logic [ADDRESS_W-1:0]       ctrl_fill_data_address,
  output logic [WAY_POINTER_W-1:0]   ctrl_fill_data_way_num,
  output logic [BURST_LEN_W-1:0]     ctrl_fill_data_beat_num,
  input  logic                       cache_fill_data_ready,
  input  logic                       cache_fill_done,
  input  logic [TABLE_ENTRIES_W-1:0] cache_fill_done_id,
  output logic [TABLE_ENTRIES-1:0]   fill_id_busy_vec,
  output logic                       fill_err
);

  fill_req_t                 req_in;
  fill_req_t                 q_head;
  logic                      q_full;
  logic                      q_empty;
  logic                      q_pop;
  logic                      req_fire;
  logic                      beat_fire;
  logic                      st_free;
  logic                      stage_ld;
  logic                      st_valid;
  fill_req_t                 st_q;
  logic                      dv_q;
  fill_beat_t                dq;
  logic [BURST_LEN_W-1:0]    beat_cnt;
  logic [TABLE_ENTRIES-1:0]  busy_q;
  logic                      q_head_unused;

  assign req_in = '{id:       fill_req_id,
                    address:  fill_req_address,
                    way:      fill_req_way_num,
                    state:    fill_req_state,
                    security: fill_req_security,
                    beat:     fill_req_beat_num};

  // The state slot is free if empty or being handshaken this cycle.
  assign st_free        = !st_valid || cache_fill_ready;
  assign fill_req_ready = st_free && !q_full && !busy_q[fill_req_id] && (fill_req_state != '0);
  assign req_fire       = fill_req_valid && fill_req_ready;

  assign stage_ld       = !dv_q || cache_fill_data_ready;
  assign beat_in_ready  = !q_empty && stage_ld;
  assign beat_fire      = beat_in_valid && beat_in_ready;
  assign q_pop          = beat_fire && (beat_cnt == BURST_LEN_W'(MAX_BEAT - 1));

  ccp_fill_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_req_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (req_fire),
    .push_data (req_in),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_valid <= 1'b0;
      st_q     <= '0;
    end else if (req_fire) begin
      st_valid <= 1'b1;
      st_q     <= req_in;
    end else if (cache_fill_ready) begin
      st_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dv_q     <= 1'b0;
      dq       <= '0;
      beat_cnt <= '0;
    end else begin
      if (beat_fire) begin
        dv_q       <= 1'b1;
        dq.data    <= beat_in_data;
        dq.id      <= q_head.id;
        dq.address <= q_head.address;
        dq.way     <= q_head.way;
        dq.beat    <= beat_at(q_head.beat, beat_cnt);
        beat_cnt   <= q_pop ? '0 : beat_cnt + BURST_LEN_W'(1);
      end else if (cache_fill_data_ready) begin
        dv_q <= 1'b0;
      end
    end
  end

  // A new request's set wins over a done clear for the same id (only reachable on a stray done).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      if (cache_fill_done) busy_q[cache_fill_done_id] <= 1'b0;
      if (req_fire)        busy_q[fill_req_id]        <= 1'b1;
    end
  end

`ifdef CCP_FILL_TX_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((cache_fill_done && !busy_q[cache_fill_done_id]) ||
                 (fill_req_valid && (fill_req_state == '0))) begin
      err_q <= 1'b1;
    end
  end
  assign fill_err = err_q;
`else
  assign fill_err = 1'b0;
`endif

  assign q_head_unused = ^{q_head.state, q_head.security};

  assign ctrl_fill_valid         = st_valid;
  assign ctrl_fill_address       = st_q.address;
  assign ctrl_fill_way_num       = st_q.way;
  assign ctrl_fill_state         = st_q.state;
  assign ctrl_fill_security      = st_q.security;
  assign ctrl_fill_data_valid    = dv_q;
  assign ctrl_fill_data          = dq.data;
  assign ctrl_fill_data_id       = dq.id;
  assign ctrl_fill_data_address  = dq.address;
  assign ctrl_fill_data_way_num  = dq.way;
  assign ctrl_fill_data_beat_num = dq.beat;
  assign fill_id_busy_vec        = busy_q;

endmodule

// File: tb/tb_ccp_fill_ctrl_tx.sv
// Directed bench for ccp_fill_ctrl_tx; fill_err expectations follow CCP_FILL_TX_ERR_CHK_EN.
module tb_ccp_fill_ctrl_tx;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fill_req_valid;
  logic         fill_req_ready;
  logic [5:0]   fill_req_id;
  logic [31:0]  fill_req_address;
  logic [0:0]   fill_req_way_num;
  logic [1:0]   fill_req_state;
  logic         fill_req_security;
  logic [1:0]   fill_req_beat_num;
  logic         beat_in_valid;
  logic         beat_in_ready;
  logic [128:0] beat_in_data;
  logic         ctrl_fill_valid;
  logic [31:0]  ctrl_fill_address;
  logic [0:0]   ctrl_fill_way_num;
  logic [1:0]   ctrl_fill_state;
  logic         ctrl_fill_security;
  logic         cache_fill_ready;
  logic         ctrl_fill_data_valid;
  logic [128:0] ctrl_fill_data;
  logic [5:0]   ctrl_fill_data_id;
  logic [31:0]  ctrl_fill_data_address;
  logic [0:0]   ctrl_fill_data_way_num;
  logic [1:0]   ctrl_fill_data_beat_num;
  logic         cache_fill_data_ready;
  logic         cache_fill_done;
  logic [5:0]   cache_fill_done_id;
  logic [63:0]  fill_id_busy_vec;
  logic         fill_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ccp_fill_ctrl_tx dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .fill_req_valid          (fill_req_valid),
    .fill_req_ready          (fill_req_ready),
    .fill_req_id             (fill_req_id),
    .fill_req_address        (fill_req_address),
    .fill_req_way_num        (fill_req_way_num),
    .fill_req_state          (fill_req_state),
    .fill_req_security       (fill_req_security),
    .fill_req_beat_num       (fill_req_beat_num),
    .beat_in_valid           (beat_in_valid),
    .beat_in_ready           (beat_in_ready),
    .beat_in_data            (beat_in_data),
    .ctrl_fill_valid         (ctrl_fill_valid),
    .ctrl_fill_address       (ctrl_fill_address),
    .ctrl_fill_way_num       (ctrl_fill_way_num),
    .ctrl_fill_state         (ctrl_fill_state),
    .ctrl_fill_security      (ctrl_fill_security),
    .cache_fill_ready        (cache_fill_ready),
    .ctrl_fill_data_valid    (ctrl_fill_data_valid),
    .ctrl_fill_data          (ctrl_fill_data),
    .ctrl_fill_data_id       (ctrl_fill_data_id),
    .ctrl_fill_data_address  (ctrl_fill_data_address),
    .ctrl_fill_data_way_num  (ctrl_fill_data_way_num),
    .ctrl_fill_data_beat_num (ctrl_fill_data_beat_num),
    .cache_fill_data_ready   (cache_fill_data_ready),
    .cache_fill_done         (cache_fill_done),
    .cache_fill_done_id      (cache_fill_done_id),
    .fill_id_busy_vec        (fill_id_busy_vec),
    .fill_err                (fill_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input logic [5:0] id);
    return 32'h8000_0000 | {20'h0, id, 6'h0};
  endfunction

  function automatic logic [1:0] state_of(input logic [5:0] id);
    return 2'(1 + (id % 3));
  endfunction

  function automatic logic [128:0] bdat(input logic [5:0] id, input int unsigned i);
    return {1'b1, {30{4'h5}}, id, 2'(i)};
  endfunction

  task automatic issue_req(input logic [5:0] id, input logic [1:0] start);
    fill_req_valid    = 1'b1;
    fill_req_id       = id;
    fill_req_address  = addr_of(id);
    fill_req_way_num  = id[0];
    fill_req_state    = state_of(id);
    fill_req_security = id[1];
    fill_req_beat_num = start;
  endtask

  task automatic send_beats(input logic [5:0] id, input logic [1:0] start,
                            input int unsigned first, input int unsigned n);
    for (int unsigned i = first; i < first + n; i++) begin
      beat_in_valid = 1'b1;
      beat_in_data  = bdat(id, i);
      #1;
      check_eq("beat_in_ready", beat_in_ready, 1'b1);
      step();
      check_eq("data_valid", ctrl_fill_data_valid, 1'b1);
      check_eq("data", ctrl_fill_data, bdat(id, i));
      check_eq("data_id", ctrl_fill_data_id, id);
      check_eq("data_addr", ctrl_fill_data_address, addr_of(id));
      check_eq("data_way", ctrl_fill_data_way_num, id[0]);
      check_eq("beat_num", ctrl_fill_data_beat_num, 2'(start + i));
    end
    beat_in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_ctrl_valid", ctrl_fill_valid, 1'b0);
    check_eq("rst_data_valid", ctrl_fill_data_valid, 1'b0);
    check_eq("rst_busy", fill_id_busy_vec, 64'h0);
    check_eq("rst_beat_ready", beat_in_ready, 1'b0);
    check_eq("rst_err", fill_err, 1'b0);
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    fill_req_valid = 1'b0; fill_req_id = '0; fill_req_address = '0; fill_req_way_num = '0;
    fill_req_state = 2'd1; fill_req_security = 1'b0; fill_req_beat_num = '0;
    beat_in_valid = 1'b0; beat_in_data = '0;
    cache_fill_ready = 1'b1; cache_fill_data_ready = 1'b1;
    cache_fill_done = 1'b0; cache_fill_done_id = '0;
    step();
    check_eq("rst_ctrl_addr", ctrl_fill_address, 32'h0);
    check_eq("rst_data", ctrl_fill_data, 129'h0);
    apply_reset();
    check_eq("idle_req_ready", fill_req_ready, 1'b1);

    // Basic fill: id 5, start beat 0
    issue_req(6'd5, 2'd0);
    #1;
    check_eq("t1_req_ready", fill_req_ready, 1'b1);
    step();
    fill_req_valid = 1'b0;
    check_eq("t1_ctrl_valid", ctrl_fill_valid, 1'b1);
    check_eq("t1_ctrl_addr", ctrl_fill_address, addr_of(6'd5));
    check_eq("t1_ctrl_way", ctrl_fill_way_num, 1'b1);
    check_eq("t1_ctrl_state", ctrl_fill_state, state_of(6'd5));
    check_eq("t1_ctrl_sec", ctrl_fill_security, 1'b0);
    check_eq("t1_busy5", fill_id_busy_vec[5], 1'b1);
    step();
    check_eq("t1_ctrl_drop", ctrl_fill_valid, 1'b0);
    send_beats(6'd5, 2'd0, 0, 4);
    #1;
    check_eq("t1_q_empty", beat_in_ready, 1'b0);
    step();
    check_eq("t1_data_drop", ctrl_fill_data_valid, 1'b0);
    check_eq("t1_busy5_held", fill_id_busy_vec[5], 1'b1);
    cache_fill_done = 1'b1; cache_fill_done_id = 6'd5;
    step();
    cache_fill_done = 1'b0;
    check_eq("t1_busy5_clr", fill_id_busy_vec[5], 1'b0);

    // Start beat 3 with state channel held off
    cache_fill_ready = 1'b0;
    issue_req(6'd6, 2'd3);
    #1;
    check_eq("t2_req_ready", fill_req_ready, 1'b1);
    step();
    check_eq("t2_ctrl_valid", ctrl_fill_valid, 1'b1);
    issue_req(6'd12, 2'd0);
    #1;
    check_eq("t2_slot_stall", fill_req_ready, 1'b0);
    fill_req_valid = 1'b0;
    step();
    check_eq("t2_ctrl_hold", ctrl_fill_valid, 1'b1);
    check_eq("t2_addr_hold", ctrl_fill_address, addr_of(6'd6));
    cache_fill_ready = 1'b1;
    step();
    check_eq("t2_ctrl_drop", ctrl_fill_valid, 1'b0);
    send_beats(6'd6, 2'd3, 0, 4);
    #1;
    check_eq("t2_popped", beat_in_ready, 1'b0);

    // Data backpressure on beat 1
    issue_req(6'd8, 2'd0);
    step();
    fill_req_valid = 1'b0;
    send_beats(6'd8, 2'd0, 0, 2);
    cache_fill_data_ready = 1'b0;
    beat_in_valid = 1'b1;
    beat_in_data  = bdat(6'd8, 2);
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      check_eq("t3_no_accept", beat_in_ready, 1'b0);
      step();
      check_eq("t3_hold_valid", ctrl_fill_data_valid, 1'b1);
      check_eq("t3_hold_data", ctrl_fill_data, bdat(6'd8, 1));
      check_eq("t3_hold_beat", ctrl_fill_data_beat_num, 2'd1);
    end
    cache_fill_data_ready = 1'b1;
    send_beats(6'd8, 2'd0, 2, 2);

    // Queue full with ids 1..4, then id 10 stalls until fill 1 completes its beats
    for (int unsigned id = 1; id <= 4; id++) begin
      issue_req(6'(id), 2'd0);
      #1;
      check_eq("t4_fill_ready", fill_req_ready, 1'b1);
      step();
    end
    issue_req(6'd10, 2'd0);
    #1;
    check_eq("t4_full_stall", fill_req_ready, 1'b0);
    send_beats(6'd1, 2'd0, 0, 3);
    #1;
    check_eq("t4_still_full", fill_req_ready, 1'b0);
    send_beats(6'd1, 2'd0, 3, 1);
    #1;
    check_eq("t4_unfull", fill_req_ready, 1'b1);
    step();
    fill_req_valid = 1'b0;
    check_eq("t4_busy10", fill_id_busy_vec[10], 1'b1);
    send_beats(6'd2, 2'd0, 0, 4);
    send_beats(6'd3, 2'd0, 0, 4);
    send_beats(6'd4, 2'd0, 0, 4);
    send_beats(6'd10, 2'd0, 0, 4);

    // Busy id 2 stalls until its done
    issue_req(6'd2, 2'd0);
    #1;
    check_eq("t4_busy_stall", fill_req_ready, 1'b0);
    step();
    check_eq("t4_busy_stall2", fill_req_ready, 1'b0);
    cache_fill_done = 1'b1; cache_fill_done_id = 6'd2;
    step();
    cache_fill_done = 1'b0;
    check_eq("t4_after_done", fill_req_ready, 1'b1);
    step();
    fill_req_valid = 1'b0;
    check_eq("t4_busy2_again", fill_id_busy_vec[2], 1'b1);
    check_eq("t4_ctrl_addr2", ctrl_fill_address, addr_of(6'd2));

    // Same-cycle done and request for id 7
    issue_req(6'd7, 2'd1);
    step();
    check_eq("t5_busy7", fill_id_busy_vec[7], 1'b1);
    cache_fill_done = 1'b1; cache_fill_done_id = 6'd7;
    #1;
    check_eq("t5_same_stall", fill_req_ready, 1'b0);
    step();
    cache_fill_done = 1'b0;
    check_eq("t5_busy7_clr", fill_id_busy_vec[7], 1'b0);
    check_eq("t5_retry_ready", fill_req_ready, 1'b1);
    step();
    fill_req_valid = 1'b0;
    check_eq("t5_busy7_end", fill_id_busy_vec[7], 1'b1);

    // Done for id 3 alongside request id 11
    issue_req(6'd11, 2'd0);
    cache_fill_done = 1'b1; cache_fill_done_id = 6'd3;
    #1;
    check_eq("t5_diff_ready", fill_req_ready, 1'b1);
    step();
    fill_req_valid = 1'b0; cache_fill_done = 1'b0;
    check_eq("t5_busy11", fill_id_busy_vec[11], 1'b1);
    check_eq("t5_busy3_clr", fill_id_busy_vec[3], 1'b0);

    // Reset mid-operation discards queued fills
    apply_reset();

    // Done for an idle id
    cache_fill_done = 1'b1; cache_fill_done_id = 6'd9;
    step();
    cache_fill_done = 1'b0;
    step();
`ifdef CCP_FILL_TX_ERR_CHK_EN
    check_eq("t6_err_set", fill_err, 1'b1);
`else
    check_eq("t6_err_tied", fill_err, 1'b0);
`endif
    apply_reset();

    // State 0 request is never accepted
    issue_req(6'd20, 2'd0);
    fill_req_state = 2'd0;
    #1;
    check_eq("t6_state0_ready", fill_req_ready, 1'b0);
    step();
    fill_req_valid = 1'b0; fill_req_state = 2'd1;
    check_eq("t6_state0_ctrl", ctrl_fill_valid, 1'b0);
    step();
`ifdef CCP_FILL_TX_ERR_CHK_EN
    check_eq("t6_err_state0", fill_err, 1'b1);
`else
    check_eq("t6_err_state0", fill_err, 1'b0);
`endif
    apply_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
